seg_display_arbiter: RTL

Shares the board's single 4-digit, active-low, multiplexed 7-segment display between several requesters, such as the calculation-method indicator, the result/countdown readout and the error reporter. It runs fixed-priority arbitration with a minimum display hold time, latches the granted requester's glyph codes and performs the digit scan. Anode blanking is inserted at the start of each digit slot to suppress ghosting. The block sits between the calculator control logic and the top-level `seg`/`an` pins.

---
 rtl/seg_display_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares one 4-digit, active-low, multiplexed 7-segment display between
//   NUM_REQ requesters. Fixed priority (index 0 highest) with a minimum hold
//   time per grant, a latched glyph register and a free-running digit scan
//   with anode blanking at the start of every digit slot.
//
// Ports
//   clk       : single clock
//   rst_n     : synchronous, active-low reset
//   req       : level-sensitive display requests, one bit per requester
//   req_data  : four 4-bit glyph codes per requester, requester i owns
//               [16i+15:16i], nibble k drives digit k (digit 0 rightmost)
//   grant     : one-hot owner, or all zero when idle (registered)
//   busy      : high whenever grant is non-zero (registered)
//   seg       : {dp,g,f,e,d,c,b,a}, active low, dp always 1 (registered)
//   an        : active-low digit enables (registered)
//
// Handshake: req is a level, not a pulse. A request seen in IDLE is granted
//   at that edge even if it falls the next cycle; once granted, the owner
//   keeps the display for at least HOLD_CYCLES cycles regardless of req.
//
// Optional feature: define SEG_BLINK_EN to blank all anodes on alternate
//   BLINK_CYCLES periods while requester 0 (the error display) owns it.

module seg_display_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int HOLD_CYCLES  = 25000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [7:0]             seg,
    output logic [3:0]             an
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] BLANK_END   = RW'(BLANK_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES - 1);

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [15:0]         disp_q, disp_d;
    logic [RW-1:0]       refresh_q, refresh_d;
    logic [1:0]          digit_q, digit_d;
    logic [7:0]          seg_q, seg_d;
    logic [3:0]          an_q, an_d;

    logic [IW-1:0]       lo_idx;
    logic                any_req;
    logic                hold_done;
    logic                owner_req;
    logic                blink_off;

    function automatic logic [7:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            4'd10:   glyph = 8'h88;
            4'd11:   glyph = 8'h83;
            4'd12:   glyph = 8'hC6;
            4'd13:   glyph = 8'hF1;
            4'd14:   glyph = 8'h87;
            default: glyph = 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] sel_data(input logic [IW-1:0] idx,
                                             input logic [16*NUM_REQ-1:0] data);
        sel_data = 16'hFFFF;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == idx) sel_data = data[16*i +: 16];
        end
    endfunction

    // Lowest-index (highest-priority) active request.
    always_comb begin
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) lo_idx = IW'(i);
        end
    end

    assign any_req   = |req;
    assign hold_done = (hold_q == HOLD_MAX);
    assign owner_req = |(req & grant_q);

    // Arbitration FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        disp_d  = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_OWN;
                    owner_d = lo_idx;
                    disp_d  = sel_data(lo_idx, req_data);
                    hold_d  = '0;
                end
            end
            default: begin
                hold_d = hold_done ? hold_q : hold_q + HW'(1);
                if (owner_req) disp_d = sel_data(owner_q, req_data);
                // After the hold expires the owner yields either to a
                // higher-priority request or, once it has let go, to anyone
                // else; with nobody waiting the display goes idle.
                if (hold_done && (!owner_req || (any_req && lo_idx < owner_q))) begin
                    if (any_req) begin
                        owner_d = lo_idx;
                        disp_d  = sel_data(lo_idx, req_data);
                        hold_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        grant_d = (state_d == ST_OWN) ? (NUM_REQ'(1) << owner_d) : '0;
        busy_d  = (state_d == ST_OWN);
    end

    // Digit scan and one-cycle output pipeline; runs regardless of FSM state.
    always_comb begin
        refresh_d = (refresh_q == REFRESH_MAX) ? '0 : refresh_q + RW'(1);
        digit_d   = (refresh_q == REFRESH_MAX) ? digit_q + 2'd1 : digit_q;
        seg_d     = glyph(disp_q[{digit_q, 2'b00} +: 4]);
        if (state_q == ST_IDLE || refresh_q < BLANK_END || blink_off) begin
            an_d = 4'hF;
        end else begin
            an_d = ~(4'b0001 << digit_q);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = (blink_cnt_q == BLINK_MAX) ? ~blink_phase_q : blink_phase_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_off = grant_q[0] & blink_phase_q;
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
            disp_q    <= 16'hFFFF;
            refresh_q <= '0;
            digit_q   <= 2'd0;
            seg_q     <= 8'hFF;
            an_q      <= 4'hF;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            hold_q    <= hold_d;
            disp_q    <= disp_d;
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule
